// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: 8-bit binary to 3-digit BCD via double dabble, multiplexed onto a scanned display.
// Optional leading-zero blanking is compiled in with LEADING_ZERO_BLANK_EN.
module bcd_scan_driver #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit,
    output logic [2:0] digit_sel
);
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q;
    logic [19:0]     sr_q, sr_d;
    logic [11:0]     adj;
    logic [2:0]      cnt_q;
    logic [11:0]     disp_q;
    logic            busy_q, done_q;
    logic [PW-1:0]   presc_q;
    logic [1:0]      idx_q;
    logic [3:0]      hun, ten, one;

    // One dabble step: correct each BCD nibble, then shift the whole register left
    always_comb begin
        adj = '0;
        for (int i = 0; i < 3; i++)
            adj[4*i +: 4] = (sr_q[8+4*i +: 4] >= 4'd5) ? sr_q[8+4*i +: 4] + 4'd3 : sr_q[8+4*i +: 4];
        sr_d = {adj[10:0], sr_q[7:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            disp_q  <= 12'hAAA;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (load) begin
                    state_q <= SHIFT;
                    sr_q    <= {12'b0, value};
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            end else begin
                sr_q  <= sr_d;
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    disp_q  <= sr_d[19:8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_comb begin
        one = disp_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        hun = (disp_q[11:8] == 4'd0) ? 4'd10 : disp_q[11:8];
        ten = (disp_q[11:8] == 4'd0 && disp_q[7:4] == 4'd0) ? 4'd10 : disp_q[7:4];
`else
        hun = disp_q[11:8];
        ten = disp_q[7:4];
`endif
        digit     = (idx_q == 2'd0) ? one : (idx_q == 2'd1) ? ten : hun;
        digit_sel = 3'b001 << idx_q;
    end

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver: directed scoreboard bench for bcd_scan_driver with SCAN_DIV=4.
module tb_bcd_scan_driver;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value;
    logic       load;
    logic       busy, done;
    logic [3:0] digit;
    logic [2:0] digit_sel;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    logic [11:0] exp_q[$];
    logic [11:0] cur_disp = 12'hAAA;

    bcd_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy), .done(done), .digit(digit), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    // Reference count of clock edges since reset release, used to predict the scan position
    always @(posedge clk) ncyc <= rst_n ? ncyc + 1 : 0;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [7:0] v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 4'd0) begin
            if (t == 4'd0) t = 4'd10;
            h = 4'd10;
        end
`endif
        return {h, t, o};
    endfunction

    function automatic logic [3:0] sel_nib(input logic [11:0] d, input logic [2:0] sel);
        return (sel == 3'b001) ? d[3:0] : (sel == 3'b010) ? d[7:4] : d[11:8];
    endfunction

    task automatic do_load(input logic [7:0] v, input bit track);
        value = v;
        load  = 1'b1;
        if (track) exp_q.push_back(model(v));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_scan(input logic [11:0] e);
        for (int s = 0; s < 3; s++) begin
            int n;
            n = 0;
            while (digit_sel !== (3'b001 << s) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("scan_sel_found", digit_sel, 3'b001 << s);
            check("scan_digit", digit, e[4*s +: 4]);
        end
    endtask

    task automatic expect_conv();
        check("busy_after_k", busy, 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                check("busy_mid", busy, 1);
                check("done_early", done, 0);
                check("old_digit_held", digit, sel_nib(cur_disp, digit_sel));
            end else begin
                check("done_k8", done, 1);
                check("busy_k8", busy, 0);
                check("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) cur_disp = exp_q.pop_front();
            end
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check_scan(cur_disp);
    endtask

    initial begin
        int done_cnt, done_at;
        rst_n = 1'b0;
        load  = 1'b0;
        value = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", digit_sel, 3'b001);
        check("rst_digit", digit, 4'd10);

        rst_n = 1'b1;
        do_load(8'd255, 1);
        expect_conv();
        do_load(8'd0, 1);
        expect_conv();
        do_load(8'd100, 1);
        expect_conv();

        // Second load while busy must be dropped
        do_load(8'd7, 1);
        @(negedge clk);
        do_load(8'd200, 0);
        done_cnt = 0;
        done_at  = 0;
        for (int c = 3; c <= 16; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_at = c;
                if (exp_q.size() > 0) cur_disp = exp_q.pop_front();
            end
        end
        check("ignored_load_done_cnt", done_cnt, 1);
        check("ignored_load_done_at", done_at, 8);
        check_scan(model(8'd7));

        // Scan cadence across a conversion completing mid-period
        do_load(8'd42, 1);
        done_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            check("scan_cadence", digit_sel, 3'b001 << ((ncyc / SD) % 3));
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() > 0) cur_disp = exp_q.pop_front();
            end
        end
        check("cadence_done_cnt", done_cnt, 1);
        check_scan(model(8'd42));

        // Reset mid-conversion
        do_load(8'd123, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sel", digit_sel, 3'b001);
        check("midrst_digit", digit, 4'd10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check_scan(12'hAAA);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_scan_driver.md
BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

Interface
REQ-001 SHALL have parameter: SCAN_DIV, default 1000, clock cycles each digit is displayed (legal range >= 2).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: value  input  8  unsigned binary number to display (0..255).
REQ-005 SHALL have port: load  input  1  one-cycle strobe requesting conversion of value.
REQ-006 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when new digits reach the display register.
REQ-008 SHALL have port: digit  output  4  BCD code for the seven-segment decoder; 0..9 = numeral, 10 = blank.
REQ-009 SHALL have port: digit_sel  output  3  one-hot active-high digit enable; bit0 = ones, bit1 = tens, bit2 = hundreds.

Function
REQ-010 SHALL implement FSM states IDLE and SHIFT.
- IDLE -> SHIFT when load=1 at a clock edge.
- SHIFT -> IDLE after exactly 8 shift cycles.
REQ-011 SHALL capture value on the IDLE edge where load=1 (edge k).
REQ-012 SHALL perform one double-dabble iteration per cycle in SHIFT: add 3 to each BCD nibble >= 5, then shift left by 1 bit, using a 12-bit BCD + 8-bit binary shift register.
REQ-013 SHALL write the three BCD digits to the display register at edge k+8 and hold done=1 for exactly the cycle following edge k+8.
REQ-014 SHALL drive busy=1 from edge k to edge k+8 and 0 otherwise.
REQ-015 SHALL ignore load while busy=1; there is no queuing, and the in-flight conversion is unaffected.
REQ-016 SHALL leave the display register unchanged until done, so the scan shows the old digits during conversion.
REQ-017 SHALL implement scan prescaler counting 0..SCAN_DIV-1 continuously; on wrap, scan index SHALL advance 0->1->2->0.
REQ-018 SHALL make digit_sel the one-hot of scan index and digit the display nibble at scan index; both are functions of registers only, with no input-to-output combinational path.
REQ-019 SHALL NOT let a display register update restart or stall the scan counter or index.
REQ-020 SHALL display digits exactly as converted when leading-zero blanking is not compiled in (see REQ-025).

Reset
REQ-021 SHALL put, while rst_n=0 (asynchronous), the following in reset:
- state = IDLE, busy = 0, done = 0, shift register = 0;
- all three display digits = 10 (blank);
- prescaler = 0, scan index = 0, digit_sel = 3'b001, digit = 10.
REQ-022 SHALL abandon a conversion on reset asserted mid-conversion, with no done pulse after release.
REQ-023 SHALL accept load from the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL use macro LEADING_ZERO_BLANK_EN.
REQ-025 With LEADING_ZERO_BLANK_EN defined, digit SHALL apply leading-zero blanking:
- hundreds shows 10 when it is 0;
- tens shows 10 when both hundreds and tens are 0;
- ones is never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, blanking logic SHALL be absent and all three converted digits SHALL be displayed.

Verification
REQ-027 SHALL cover: load with value=255 -> busy for 8 cycles, done pulse at k+8, display hundreds/tens/ones = 2/5/5.
REQ-028 SHALL cover: value=0 -> macro defined: digit sequence 0,10,10 over index 0,1,2; macro absent: 0,0,0.
REQ-029 SHALL cover: value=100 -> 0,0,1 over index 0,1,2 in both builds (tens not blanked).
REQ-030 SHALL cover: load value=7, then load value=200 two cycles later while busy -> single done, display 7.
REQ-031 SHALL cover: SCAN_DIV=4 -> digit_sel 001 for 4 cycles, then 010 for 4, then 100 for 4, then 001, unaffected by a done mid-period.
REQ-032 SHALL cover: rst_n low at shift cycle 4 -> busy=0, digits 10/10/10, digit_sel=001, no done after release.
